// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the five-stage LEGv8 pipeline.
// Owns the data memory. Performs the load or store for the instruction in MEM and
// latches the result into the MEM/WB pipeline register.
//
// Parameters:
//   DEPTH      number of 64-bit data-memory words (power of two, 2..1024)
//   ADDR_BITS  word-index width
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   MEM_WB_Stall         hold MEM/WB register and memory
//   MEM_WB_Flush         load a bubble into MEM/WB
//   RegWrite_M, MemToReg_M, MemRead_M, MemWrite_M    MEM-stage control bits
//   ALUResult_M          byte address or ALU result
//   WriteData_M          store data
//   DestinationReg_M     destination register number
//   RegWrite_W, DestinationReg_W, Result_W           register-file write port
//   MemToReg_W, ALUResult_W, MemReadData_W           registered WB fields
//   Misaligned_W         instruction in WB made a misaligned access
`timescale 1ns / 1ps

module mem_wb_stage #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_WB_Stall,
  input  logic        MEM_WB_Flush,
  input  logic        RegWrite_M,
  input  logic        MemToReg_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [63:0] ALUResult_M,
  input  logic [63:0] WriteData_M,
  input  logic [4:0]  DestinationReg_M,
  output logic        RegWrite_W,
  output logic [4:0]  DestinationReg_W,
  output logic [63:0] Result_W,
  output logic        MemToReg_W,
  output logic [63:0] ALUResult_W,
  output logic [63:0] MemReadData_W,
  output logic        Misaligned_W
);

  logic [ADDR_BITS-1:0] w_index;
  logic                 w_misaligned;
  logic                 w_store;
  logic [63:0]          w_load_data;

  logic [63:0]          r_mem [DEPTH];

  logic                 r_reg_write;
  logic [4:0]           r_dest_reg;
  logic                 r_mem_to_reg;
  logic [63:0]          r_alu_result;
  logic [63:0]          r_mem_read_data;
  logic                 r_misaligned;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH*8 bytes.
  assign w_index      = ALUResult_M[ADDR_BITS+2:3];
  assign w_misaligned = (MemRead_M | MemWrite_M) & (ALUResult_M[2:0] != 3'b000);
  assign w_store      = MemWrite_M & ~w_misaligned & ~MEM_WB_Stall;
  assign w_load_data  = (MemRead_M & ~w_misaligned) ? r_mem[w_index] : 64'h0;

  // Data memory. Flush does not suppress a store; only stall and misalignment do.
  // A store at the reset edge is dropped because reset takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 64'h0;
      end
    end else if (w_store) begin
      r_mem[w_index] <= WriteData_M;
    end
  end

  // MEM/WB register: reset > stall > flush > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write     <= 1'b0;
      r_dest_reg      <= 5'd0;
      r_mem_to_reg    <= 1'b0;
      r_alu_result    <= 64'h0;
      r_mem_read_data <= 64'h0;
      r_misaligned    <= 1'b0;
    end else if (MEM_WB_Stall) begin
      r_reg_write     <= r_reg_write;
    end else if (MEM_WB_Flush) begin
      // Bubble: kill side effects, leave data fields as they were.
      r_reg_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_misaligned    <= 1'b0;
    end else begin
      // X31 is XZR and a faulting access never writes back.
      r_reg_write     <= RegWrite_M & ~w_misaligned & (DestinationReg_M != 5'd31);
      r_dest_reg      <= DestinationReg_M;
      r_mem_to_reg    <= MemToReg_M;
      r_alu_result    <= ALUResult_M;
      r_mem_read_data <= w_load_data;
      r_misaligned    <= w_misaligned;
    end
  end

  assign RegWrite_W       = r_reg_write;
  assign DestinationReg_W = r_dest_reg;
  assign MemToReg_W       = r_mem_to_reg;
  assign ALUResult_W      = r_alu_result;
  assign MemReadData_W    = r_mem_read_data;
  assign Misaligned_W     = r_misaligned;
  assign Result_W         = r_mem_to_reg ? r_mem_read_data : r_alu_result;

endmodule
